// File: rtl/data_sampling.sv
// rtl/data_sampling.sv - UART RX oversampling stage: line synchroniser and 3-sample majority vote
// Captures rx_sync at H-1, H and H+1 (H = prescale/2) and strobes the voted bit one cycle later.
module data_sampling #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic                  data_samp_en,
  output logic                  rx_sync,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  prescale_err
);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t state, state_nxt;

  logic                  sync_ff;
  logic                  s0, s1;
  logic                  s0_nxt, s1_nxt;
  logic                  sampled_bit_nxt;
  logic                  sample_valid_nxt;
  logic                  prescale_err_nxt;
  logic                  majority;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] half_m1;
  logic [PRESCALE_W-1:0] half_p1;

  assign half     = prescale >> 1;
  assign half_m1  = half - PRESCALE_W'(1);
  assign half_p1  = half + PRESCALE_W'(1);
  assign majority = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);

  assign prescale_err_nxt = !((prescale == PRESCALE_W'(8))  ||
                              (prescale == PRESCALE_W'(16)) ||
                              (prescale == PRESCALE_W'(32)));

  always_comb begin
    state_nxt        = state;
    s0_nxt           = s0;
    s1_nxt           = s1;
    sampled_bit_nxt  = sampled_bit;
    sample_valid_nxt = 1'b0;
    if (!data_samp_en || prescale_err) begin
      state_nxt = IDLE;
      s0_nxt    = 1'b0;
      s1_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (edge_cnt == half_m1) begin
            s0_nxt    = rx_sync;
            state_nxt = COLLECT;
          end
        end
        COLLECT: begin
          if (edge_cnt == half) begin
            s1_nxt = rx_sync;
          end else if (edge_cnt == half_p1) begin
            sampled_bit_nxt  = majority;
            sample_valid_nxt = 1'b1;
            state_nxt        = IDLE;
          end else if (edge_cnt != half_m1) begin
            // Upstream counter resynchronised: the partial samples are meaningless.
            state_nxt = IDLE;
            s0_nxt    = 1'b0;
            s1_nxt    = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_ff      <= 1'b1;
      rx_sync      <= 1'b1;
      state        <= IDLE;
      s0           <= 1'b0;
      s1           <= 1'b0;
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
      prescale_err <= 1'b0;
    end else begin
      sync_ff      <= rx_in;
      rx_sync      <= sync_ff;
      state        <= state_nxt;
      s0           <= s0_nxt;
      s1           <= s1_nxt;
      sampled_bit  <= sampled_bit_nxt;
      sample_valid <= sample_valid_nxt;
      prescale_err <= prescale_err_nxt;
    end
  end

endmodule

// File: tb/tb_data_sampling.sv
// tb/tb_data_sampling.sv - directed self-checking bench for data_sampling
// Stimulus is described as the rx_sync value wanted at each edge; rx_in is driven two cycles ahead.
module tb_data_sampling;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic [5:0] edge_cnt;
  logic       data_samp_en;
  logic       rx_sync;
  logic       sampled_bit;
  logic       sample_valid;
  logic       prescale_err;

  int checks;
  int errors;

  logic dsync [0:80];
  logic den   [0:80];
  int   decnt [0:80];
  logic strb  [0:80];
  logic sbv   [0:80];
  logic expv  [0:80];
  int   cur_p;

  data_sampling #(.PRESCALE_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .prescale     (prescale),
    .edge_cnt     (edge_cnt),
    .data_samp_en (data_samp_en),
    .rx_sync      (rx_sync),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid),
    .prescale_err (prescale_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int p, input logic bg);
    cur_p = p;
    for (int t = 0; t <= 80; t++) begin
      decnt[t] = t % p;
      dsync[t] = bg;
      den[t]   = 1'b1;
      expv[t]  = 1'b0;
    end
  endtask

  // Plays n cycles; strb[n] holds the trailing idle cycle.
  task automatic play(input int n);
    prescale     = 6'(cur_p);
    data_samp_en = 1'b0;
    edge_cnt     = 6'd0;
    for (int j = 0; j < 2; j++) begin
      rx_in = dsync[j];
      tick();
    end
    for (int t = 0; t < n; t++) begin
      rx_in        = (t + 2 < n) ? dsync[t+2] : 1'b1;
      edge_cnt     = 6'(decnt[t]);
      data_samp_en = den[t];
      tick();
      strb[t] = sample_valid;
      sbv[t]  = sampled_bit;
    end
    data_samp_en = 1'b0;
    edge_cnt     = 6'd0;
    tick();
    strb[n] = sample_valid;
    sbv[n]  = sampled_bit;
  endtask

  task automatic test_reset();
    rst = 1'b0; rx_in = 1'b0; prescale = 6'd12; edge_cnt = 6'd0; data_samp_en = 1'b1;
    tick();
    checks += 4;
    if (rx_sync !== 1'b1)      begin errors++; $display("FAIL reset_rx_sync got %b want 1", rx_sync); end
    if (sampled_bit !== 1'b1)  begin errors++; $display("FAIL reset_sampled_bit got %b want 1", sampled_bit); end
    if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sample_valid got %b want 0", sample_valid); end
    if (prescale_err !== 1'b0) begin errors++; $display("FAIL reset_prescale_err got %b want 0", prescale_err); end
    rst = 1'b1; prescale = 6'd8; data_samp_en = 1'b0;
    tick();
    checks++;
    if (rx_sync !== 1'b1) begin errors++; $display("FAIL sync_latency1 got %b want 1", rx_sync); end
    tick();
    checks++;
    if (rx_sync !== 1'b0) begin errors++; $display("FAIL sync_latency2 got %b want 0", rx_sync); end
    rx_in = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_p8_low();
    fill(8, 1'b0);
    expv[5] = 1'b1;
    play(8);
    for (int t = 0; t <= 8; t++) begin
      checks++;
      if (strb[t] !== expv[t]) begin errors++; $display("FAIL p8_strobe t=%0d got %b want %b", t, strb[t], expv[t]); end
    end
    checks++;
    if (sbv[5] !== 1'b0) begin errors++; $display("FAIL p8_bit got %b want 0", sbv[5]); end
  endtask

  task automatic test_p16_vote();
    fill(16, 1'b1);
    dsync[7] = 1'b1; dsync[8] = 1'b0; dsync[9] = 1'b1;
    expv[9] = 1'b1;
    play(16);
    for (int t = 0; t <= 16; t++) begin
      checks++;
      if (strb[t] !== expv[t]) begin errors++; $display("FAIL p16_strobe t=%0d got %b want %b", t, strb[t], expv[t]); end
    end
    checks += 2;
    if (sbv[8] !== 1'b0) begin errors++; $display("FAIL p16_bit_before got %b want 0", sbv[8]); end
    if (sbv[9] !== 1'b1) begin errors++; $display("FAIL p16_bit got %b want 1", sbv[9]); end
  endtask

  task automatic test_p32_vote();
    fill(32, 1'b1);
    dsync[15] = 1'b0; dsync[16] = 1'b0; dsync[17] = 1'b1;
    expv[17] = 1'b1;
    play(32);
    for (int t = 0; t <= 32; t++) begin
      checks++;
      if (strb[t] !== expv[t]) begin errors++; $display("FAIL p32_strobe t=%0d got %b want %b", t, strb[t], expv[t]); end
    end
    checks++;
    if (sbv[17] !== 1'b0) begin errors++; $display("FAIL p32_bit got %b want 0", sbv[17]); end
  endtask

  task automatic test_enable_drop();
    fill(16, 1'b1);
    for (int t = 8; t < 16; t++) den[t] = 1'b0;
    play(16);
    for (int t = 0; t <= 16; t++) begin
      checks++;
      if (strb[t] !== 1'b0) begin errors++; $display("FAIL en_drop_strobe t=%0d got %b want 0", t, strb[t]); end
    end
    checks++;
    if (sbv[16] !== 1'b0) begin errors++; $display("FAIL en_drop_hold got %b want 0", sbv[16]); end
  endtask

  task automatic test_abort();
    fill(16, 1'b1);
    for (int t = 8; t < 14; t++) decnt[t] = t + 2;
    play(14);
    for (int t = 0; t <= 14; t++) begin
      checks++;
      if (strb[t] !== 1'b0) begin errors++; $display("FAIL abort_strobe t=%0d got %b want 0", t, strb[t]); end
    end
    checks++;
    if (sbv[14] !== 1'b0) begin errors++; $display("FAIL abort_hold got %b want 0", sbv[14]); end
  endtask

  task automatic test_back_to_back();
    fill(8, 1'b1);
    dsync[3]  = 1'b0; dsync[4]  = 1'b0; dsync[5]  = 1'b0;
    dsync[11] = 1'b1; dsync[12] = 1'b1; dsync[13] = 1'b0;
    expv[5] = 1'b1; expv[13] = 1'b1;
    play(16);
    for (int t = 0; t <= 16; t++) begin
      checks++;
      if (strb[t] !== expv[t]) begin errors++; $display("FAIL b2b_strobe t=%0d got %b want %b", t, strb[t], expv[t]); end
    end
    checks += 2;
    if (sbv[5] !== 1'b0)  begin errors++; $display("FAIL b2b_bit0 got %b want 0", sbv[5]); end
    if (sbv[13] !== 1'b1) begin errors++; $display("FAIL b2b_bit1 got %b want 1", sbv[13]); end
  endtask

  task automatic test_prescale_err();
    prescale = 6'd12; data_samp_en = 1'b0; edge_cnt = 6'd0;
    tick();
    checks++;
    if (prescale_err !== 1'b1) begin errors++; $display("FAIL presc_err_set got %b want 1", prescale_err); end
    fill(12, 1'b0);
    play(12);
    for (int t = 0; t <= 12; t++) begin
      checks++;
      if (strb[t] !== 1'b0) begin errors++; $display("FAIL presc_strobe t=%0d got %b want 0", t, strb[t]); end
    end
    checks += 2;
    if (sbv[12] !== 1'b1)      begin errors++; $display("FAIL presc_hold got %b want 1", sbv[12]); end
    if (prescale_err !== 1'b1) begin errors++; $display("FAIL presc_err_hold got %b want 1", prescale_err); end
    prescale = 6'd16;
    tick();
    checks++;
    if (prescale_err !== 1'b0) begin errors++; $display("FAIL presc_err_clear got %b want 0", prescale_err); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_p8_low();
    test_p16_vote();
    test_p32_vote();
    test_enable_drop();
    test_abort();
    test_back_to_back();
    test_prescale_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
